// File: rtl/dispatch_buffer_pkg.sv
// Shared types and sizing for the dispatch buffer: lane width, default depth,
// and the renamed-instruction packet handed to the reservation station.
package dispatch_buffer_pkg;

    localparam int unsigned N        = 3;
    localparam int unsigned DB_SZ    = 16;
    localparam int unsigned DB_CNT_W = $clog2(DB_SZ + 1);

    typedef enum logic [1:0] {
        FU_ALU = 2'd0,
        FU_MUL = 2'd1,
        FU_MEM = 2'd2,
        FU_BR  = 2'd3
    } fu_type_e;

    typedef struct packed {
        fu_type_e   fu;
        logic [6:0] opcode;
        logic [5:0] dest_prf;
        logic [5:0] src1_prf;
        logic [5:0] src2_prf;
        logic [4:0] rob_idx;
    } RS_ENTRY_PACKET;

endpackage

// File: rtl/dispatch_buffer_if.sv
// Rename-side push lanes, RS-side dispatch lanes and the slot/space counters
// exchanged with the dispatch buffer.
interface dispatch_buffer_if
    import dispatch_buffer_pkg::*;
#(
    parameter int unsigned CNT_W = DB_CNT_W
) ();

    logic                   [N-1:0] in_valid;
    RS_ENTRY_PACKET         [N-1:0] in_entries;
    logic               [CNT_W-1:0] free_space;
    logic               [CNT_W-1:0] rs_free_slots;
    logic               [CNT_W-1:0] rob_free_slots;
    logic                   [N-1:0] out_valid;
    RS_ENTRY_PACKET         [N-1:0] out_entries;
    logic               [CNT_W-1:0] occupancy;

    modport master (
        output in_valid, in_entries, rs_free_slots, rob_free_slots,
        input  free_space, out_valid, out_entries, occupancy
    );

    modport slave (
        input  in_valid, in_entries, rs_free_slots, rob_free_slots,
        output free_space, out_valid, out_entries, occupancy
    );

endinterface

// File: rtl/dispatch_buffer_min_select.sv
// Four-input unsigned minimum; selects how many lanes may dispatch this cycle.
module dispatch_buffer_min_select #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    input  logic [W-1:0] d,
    output logic [W-1:0] y
);

    logic [W-1:0] ab;
    logic [W-1:0] cd;

    always_comb begin
        ab = (a < b) ? a : b;
        cd = (c < d) ? c : d;
        y  = (ab < cd) ? ab : cd;
    end

endmodule

// File: rtl/dispatch_buffer.sv
// In-order N-wide circular buffer between rename and the reservation station;
// dispatches min(N, occupancy, rs slots, rob slots) oldest entries per cycle.
module dispatch_buffer
    import dispatch_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = DB_SZ
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    dispatch_buffer_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    RS_ENTRY_PACKET   storage [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] free_q;

    logic [CNT_W-1:0] push_req;
    logic [CNT_W-1:0] push_acc;
    logic [CNT_W-1:0] k_raw;
    logic [CNT_W-1:0] pop_cnt;
    logic [CNT_W-1:0] space;
    logic [CNT_W-1:0] count_next;
    logic             run;

    dispatch_buffer_min_select #(.W(CNT_W)) u_min_select (
        .a (CNT_W'(N)),
        .b (count),
        .c (bus.rs_free_slots),
        .d (bus.rob_free_slots),
        .y (k_raw)
    );

    // Only the contiguous run of valid lanes starting at lane 0 is pushed.
    always_comb begin
        push_req = '0;
        run      = 1'b1;
        for (int unsigned i = 0; i < N; i++) begin
            run = run & bus.in_valid[i];
            if (run) push_req = push_req + CNT_W'(1);
        end
    end

    // Lanes popped this cycle free room for same-cycle pushes, so a full
    // buffer can still accept as many entries as it dispatches.
    always_comb begin
        pop_cnt    = (reset || flush) ? '0 : k_raw;
        space      = free_q + pop_cnt;
        push_acc   = (push_req < space) ? push_req : space;
        count_next = count + push_acc - pop_cnt;
    end

    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            bus.out_valid[i]   = CNT_W'(i) < pop_cnt;
            bus.out_entries[i] = storage[head + PTR_W'(i)];
        end
        bus.free_space = free_q;
        bus.occupancy  = count;
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            free_q <= CNT_W'(DEPTH);
        end else begin
            head   <= head + PTR_W'(pop_cnt);
            tail   <= tail + PTR_W'(push_acc);
            count  <= count_next;
            free_q <= CNT_W'(DEPTH) - count_next;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && !flush) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (CNT_W'(i) < push_acc) storage[tail + PTR_W'(i)] <= bus.in_entries[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && !flush) begin
            assert ((bus.in_valid & (bus.in_valid + N'(1))) == '0);
            assert (push_req <= space);
        end
    end

endmodule

// File: tb/tb_dispatch_buffer.sv
// Randomized and directed checks of dispatch_buffer against a queue-based
// model of the in-order buffer (N=3, DEPTH=8).
module tb_dispatch_buffer;
    import dispatch_buffer_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = 4;

    logic clock = 1'b0;
    logic reset;
    logic flush;

    int unsigned tests = 0;
    int unsigned fails = 0;
    RS_ENTRY_PACKET q[$];

    dispatch_buffer_if #(.CNT_W(CW)) bus ();

    dispatch_buffer #(.DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL timeout: observed no finish, expected finish before 500000");
        $fatal(1, "timeout");
    end

    function automatic int unsigned kcalc(input int unsigned occ, input int unsigned rs,
                                          input int unsigned rob);
        int unsigned m;
        m = N;
        if (occ < m) m = occ;
        if (rs  < m) m = rs;
        if (rob < m) m = rob;
        return m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic cycle(input bit fl, input int unsigned np_in, input int unsigned rs,
                         input int unsigned rob);
        int unsigned    k, room, np;
        RS_ENTRY_PACKET lanes [N];
        @(negedge clock);
        k    = fl ? 0 : kcalc(q.size(), rs, rob);
        room = DEPTH - q.size() + k;
        np   = (!fl && np_in > room) ? room : np_in;
        reset = 1'b0;
        flush = fl;
        bus.rs_free_slots  = CW'(rs);
        bus.rob_free_slots = CW'(rob);
        for (int i = 0; i < N; i++) begin
            lanes[i] = RS_ENTRY_PACKET'($urandom);
            bus.in_entries[i] = lanes[i];
            bus.in_valid[i]   = (i < np);
        end
        #1;
        chk("occupancy",  32'(bus.occupancy),  32'(q.size()));
        chk("free_space", 32'(bus.free_space), 32'(DEPTH - q.size()));
        chk("out_valid",  32'(bus.out_valid),  (32'd1 << k) - 32'd1);
        for (int i = 0; i < int'(k); i++)
            chk($sformatf("out_entry%0d", i), 32'(bus.out_entries[i]), 32'(q[i]));
        if (fl) begin
            q.delete();
        end else begin
            repeat (k) void'(q.pop_front());
            for (int i = 0; i < int'(np); i++) q.push_back(lanes[i]);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        flush = 1'b0;
        bus.in_valid = '1;
        @(posedge clock);
        q.delete();
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        bus.in_valid       = '0;
        bus.in_entries     = '0;
        bus.rs_free_slots  = '0;
        bus.rob_free_slots = '0;
        repeat (2) @(posedge clock);

        // reset state with generous slots: nothing to dispatch
        cycle(0, 0, 8, 8);

        // fill with back-end stalled, up to full
        cycle(0, 3, 0, 0);
        cycle(0, 3, 0, 0);
        cycle(0, 2, 0, 0);
        cycle(0, 0, 0, 0);

        // partial dispatch limited by rs slots
        cycle(1, 3, 8, 8);
        cycle(0, 3, 0, 0);
        cycle(0, 2, 0, 0);
        cycle(0, 0, 2, 7);
        cycle(0, 0, 0, 0);

        // walk head to slot 6, then dispatch across the wrap
        cycle(1, 0, 0, 0);
        cycle(0, 3, 0, 0);
        cycle(0, 3, 0, 0);
        cycle(0, 2, 3, 3);
        cycle(0, 2, 3, 3);
        cycle(0, 3, 3, 3);

        // full with simultaneous pop and push
        cycle(0, 3, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(0, 3, 3, 3);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 8, 8);

        // flush with a live push
        cycle(1, 0, 0, 0);
        cycle(0, 3, 0, 0);
        cycle(0, 3, 0, 0);
        cycle(1, 3, 8, 8);
        cycle(0, 0, 8, 8);

        // single push: dispatchable one cycle later
        cycle(0, 1, 8, 8);
        cycle(0, 0, 8, 8);
        cycle(0, 0, 8, 8);

        // reset mid-operation
        cycle(0, 3, 0, 0);
        cycle(0, 3, 1, 1);
        do_reset();
        cycle(0, 0, 8, 8);

        for (int t = 0; t < 600; t++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            cycle($urandom_range(0, 39) == 0, $urandom_range(0, N),
                  $urandom_range(0, 8), $urandom_range(0, 8));
        end
        cycle(0, 0, 8, 8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
